// File: rtl/alu_issue.sv
// Decode/issue stage producing aluc/A/B for the RV32I ALU over a valid/ready handshake.
// ALU_ISSUE_SKID_EN adds a skid entry so in_ready_o is registered (no out_ready_i -> in_ready_o path).
module alu_issue #(
   parameter int XLEN = 32,
   parameter int ACW  = 5
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [XLEN-1:0] A_o,
   output logic [XLEN-1:0] B_o,
   output logic [ACW-1:0]  aluc_o,
   output logic [4:0]      rd_o,
   output logic            we_o,
   output logic            illegal_o
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [ACW-1:0] AC_ADD  = 5'b00000;
   localparam logic [ACW-1:0] AC_SLL  = 5'b00001;
   localparam logic [ACW-1:0] AC_SRL  = 5'b00101;
   localparam logic [ACW-1:0] AC_SRA  = 5'b01101;
   localparam logic [ACW-1:0] AC_BEQ  = 5'b01110;
   localparam logic [ACW-1:0] AC_BNE  = 5'b01111;
   localparam logic [ACW-1:0] AC_BLT  = 5'b10100;
   localparam logic [ACW-1:0] AC_BGE  = 5'b10001;
   localparam logic [ACW-1:0] AC_BLTU = 5'b10110;
   localparam logic [ACW-1:0] AC_BGEU = 5'b10011;
   localparam logic [ACW-1:0] AC_JMP  = 5'b11111;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [ACW-1:0]  aluc;
      logic [4:0]      rd;
      logic            we;
      logic            ill;
   } issue_t;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      rd_f;
   logic [XLEN-1:0] imm_i, imm_u, shamt;

   assign opc   = instr_i[6:0];
   assign f3    = instr_i[14:12];
   assign f7    = instr_i[31:25];
   assign rd_f  = instr_i[11:7];
   assign imm_i = XLEN'($signed(instr_i[31:20]));
   assign imm_u = XLEN'($signed({instr_i[31:12], 12'b0}));
   assign shamt = XLEN'(instr_i[24:20]);

   issue_t          dec;
   logic            legal, wr;
   logic [XLEN-1:0] a_d, b_d;
   logic [ACW-1:0]  code;

   always_comb begin
      legal = 1'b1;
      wr    = 1'b1;
      a_d   = rs1_data_i;
      b_d   = rs2_data_i;
      code  = AC_ADD;
      case (opc)
         OPC_OP: begin
            code  = {1'b0, f7[5], f3};
            legal = (f7 == 7'b0000000) ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            // ALU evaluates SLL as B<<A and SUB as B-A
            if (f3 == 3'b001 || (f3 == 3'b000 && f7[5])) begin
               a_d = rs2_data_i;
               b_d = rs1_data_i;
            end
         end
         OPC_IMM: begin
            code = {2'b00, f3};
            b_d  = imm_i;
            if (f3 == 3'b001) begin
               legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               code  = AC_SLL;
               a_d   = shamt;
               b_d   = rs1_data_i;
            end else if (f3 == 3'b101) begin
               legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
               code  = instr_i[30] ? AC_SRA : AC_SRL;
               b_d   = shamt;
            end
         end
         OPC_BRANCH: begin
            wr = 1'b0;
            case (f3)
               3'b000:  code = AC_BEQ;
               3'b001:  code = AC_BNE;
               3'b100:  code = AC_BLT;
               3'b101:  code = AC_BGE;
               3'b110:  code = AC_BLTU;
               3'b111:  code = AC_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_JAL, OPC_JALR: begin
            code = AC_JMP;
            a_d  = pc_i + XLEN'(4);
            b_d  = '0;
         end
         OPC_LUI: begin
            a_d = '0;
            b_d = imm_u;
         end
         OPC_AUIPC: begin
            a_d = pc_i;
            b_d = imm_u;
         end
         default: legal = 1'b0;
      endcase

      dec = '0;
      if (!legal) begin
         dec.ill = 1'b1;
      end else begin
         dec.a    = a_d;
         dec.b    = b_d;
         dec.aluc = code;
         dec.rd   = wr ? rd_f : 5'd0;
         dec.we   = wr && (rd_f != 5'd0);
      end
   end

   issue_t out_q;
   logic   out_vld;
   logic   in_xfer;

   assign in_xfer = in_valid_i & in_ready_o;

`ifdef ALU_ISSUE_SKID_EN
   issue_t skid_q;
   logic   skid_vld;

   // Ready depends only on state, so back-pressure never ripples upstream combinationally
   assign in_ready_o = !skid_vld;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_vld  <= 1'b0;
         out_q    <= '0;
         skid_vld <= 1'b0;
         skid_q   <= '0;
      end else if (!out_vld || out_ready_i) begin
         if (skid_vld) begin
            out_q    <= skid_q;
            out_vld  <= 1'b1;
            skid_vld <= 1'b0;
         end else if (in_xfer) begin
            out_q   <= dec;
            out_vld <= 1'b1;
         end else begin
            out_vld <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_q   <= dec;
         skid_vld <= 1'b1;
      end
   end
`else
   assign in_ready_o = !out_vld || out_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         out_vld <= 1'b0;
         out_q   <= '0;
      end else if (in_xfer) begin
         out_q   <= dec;
         out_vld <= 1'b1;
      end else if (out_ready_i) begin
         out_vld <= 1'b0;
      end
   end
`endif

   assign out_valid_o = out_vld;
   assign A_o         = out_q.a;
   assign B_o         = out_q.b;
   assign aluc_o      = out_q.aluc;
   assign rd_o        = out_q.rd;
   assign we_o        = out_q.we;
   assign illegal_o   = out_q.ill;

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue: decode table, back-pressure stream, mid-stream reset.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, pc, rs1, rs2, a_o, b_o;
   logic [4:0]  aluc, rd;
   logic        we, ill;

   always #5 clk = ~clk;

   alu_issue dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .instr_i(instr), .pc_i(pc), .rs1_data_i(rs1), .rs2_data_i(rs2),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .A_o(a_o), .B_o(b_o), .aluc_o(aluc), .rd_o(rd), .we_o(we), .illegal_o(ill)
   );

   typedef struct {
      string       name;
      logic [31:0] instr, pc, rs1, rs2, a, b;
      logic [4:0]  aluc, rd;
      logic        we, ill;
   } vec_t;

   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [31:0] i, p, r1, r2, ea, eb,
                      input logic [4:0] ec, er, input logic ew, ei);
      vec_t v;
      v.name = nm; v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
      v.a = ea; v.b = eb; v.aluc = ec; v.rd = er; v.we = ew; v.ill = ei;
      vq.push_back(v);
   endtask

   int sent, got, cyc, first_hs, last_hs;

   initial begin
      //   name     instr         pc            rs1           rs2           A             B             aluc      rd  we  ill
      add("sub",   32'h402081B3, 32'h0,        32'h10,       32'h3,        32'h3,        32'h10,       5'b01000, 3, 1, 0);
      add("srai",  32'h40435293, 32'h0,        32'h80000000, 32'h0,        32'h80000000, 32'h4,        5'b01101, 5, 1, 0);
      add("slli",  32'h00431293, 32'h0,        32'h12345678, 32'h0,        32'h4,        32'h12345678, 5'b00001, 5, 1, 0);
      add("bgeu",  32'h0020F463, 32'h0,        32'h5,        32'h7,        32'h5,        32'h7,        5'b10011, 0, 0, 0);
      add("jal",   32'h000000EF, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h0,        32'h0,        5'b11111, 1, 1, 0);
      add("ill7f", 32'h0000057F, 32'h0,        32'h11,       32'h22,       32'h0,        32'h0,        5'b00000, 0, 0, 1);
      add("addi",  32'hFFF00093, 32'h0,        32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 5'b00000, 1, 1, 0);
      add("mul",   32'h022081B3, 32'h0,        32'h1,        32'h2,        32'h0,        32'h0,        5'b00000, 0, 0, 1);
      add("lui",   32'h123453B7, 32'h0,        32'h0,        32'h0,        32'h0,        32'h12345000, 5'b00000, 7, 1, 0);
      add("auipc", 32'h00001417, 32'h1000,     32'h0,        32'h0,        32'h1000,     32'h1000,     5'b00000, 8, 1, 0);
      add("addx0", 32'h00208033, 32'h0,        32'h9,        32'h4,        32'h9,        32'h4,        5'b00000, 0, 0, 0);
      add("sll",   32'h00209233, 32'h0,        32'h1,        32'h3,        32'h3,        32'h1,        5'b00001, 4, 1, 0);
      add("br010", 32'h0020A063, 32'h0,        32'h1,        32'h2,        32'h0,        32'h0,        5'b00000, 0, 0, 1);
      add("orf7",  32'h4020E1B3, 32'h0,        32'h1,        32'h2,        32'h0,        32'h0,        5'b00000, 0, 0, 1);
      add("jalr",  32'h000100E7, 32'h100,      32'h0,        32'h0,        32'h104,      32'h0,        5'b11111, 1, 1, 0);
      add("srli",  32'h00435293, 32'h0,        32'h80000000, 32'h0,        32'h80000000, 32'h4,        5'b00101, 5, 1, 0);
      add("blt",   32'h0020C063, 32'h0,        32'h1,        32'h2,        32'h1,        32'h2,        5'b10100, 0, 0, 0);

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = '0; pc = '0; rs1 = '0; rs2 = '0;
      #3;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_A", a_o, 32'h0);
      chk("rst_B", b_o, 32'h0);
      chk("rst_aluc", 32'(aluc), 32'h0);
      chk("rst_rd_we_ill", {27'b0, rd, we, ill} , 32'h0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rst_in_ready", 32'(in_ready), 32'h1);

      // Back-to-back stream: each vector appears the cycle after its transfer
      foreach (vq[i]) begin
         @(negedge clk);
         in_valid = 1'b1; out_ready = 1'b1;
         instr = vq[i].instr; pc = vq[i].pc; rs1 = vq[i].rs1; rs2 = vq[i].rs2;
         #1 chk({vq[i].name, "_in_ready"}, 32'(in_ready), 32'h1);
         @(posedge clk); #1;
         chk({vq[i].name, "_valid"}, 32'(out_valid), 32'h1);
         chk({vq[i].name, "_A"}, a_o, vq[i].a);
         chk({vq[i].name, "_B"}, b_o, vq[i].b);
         chk({vq[i].name, "_aluc"}, 32'(aluc), 32'(vq[i].aluc));
         chk({vq[i].name, "_rd"}, 32'(rd), 32'(vq[i].rd));
         chk({vq[i].name, "_we"}, 32'(we), 32'(vq[i].we));
         chk({vq[i].name, "_ill"}, 32'(ill), 32'(vq[i].ill));
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1 chk("drain_valid", 32'(out_valid), 32'h0);

      // Four ADDIs (B = 1..4) with the ALU stalled for the first three cycles
      sent = 0; got = 0; cyc = 0; first_hs = -1; last_hs = -1;
      rs1 = '0; pc = '0;
      while (got < 4 && cyc < 40) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         in_valid  = (sent < 4);
         instr     = {12'(sent + 1), 5'd0, 3'b000, 5'd1, 7'b0010011};
         #1;
         if (out_valid && out_ready) begin
            chk("bp_order", b_o, 32'(got + 1));
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            got++;
         end else if (out_valid) begin
            chk("bp_hold", b_o, 32'(got + 1));
         end
         if (in_valid && in_ready) sent++;
         cyc++;
      end
      chk("bp_count", 32'(got), 32'd4);
      chk("bp_first_hs", 32'(first_hs), 32'd3);
      chk("bp_last_hs", 32'(last_hs), 32'd6);
      @(negedge clk); in_valid = 1'b0;
      #1 chk("bp_no_dup", 32'(out_valid), 32'h0);

      // Mid-stream reset with the output (and skid, if present) occupied
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1;
      instr = 32'h402081B3; rs1 = 32'h10; rs2 = 32'h3;
      @(posedge clk);
      @(negedge clk); instr = 32'hFFF00093;
      @(posedge clk); #1;
      chk("pre_rst_valid", 32'(out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'h0);
      chk("mid_rst_A", a_o, 32'h0);
      chk("mid_rst_B", b_o, 32'h0);
      chk("mid_rst_misc", {22'b0, aluc, rd, we, ill}, 32'h0);
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      #1 chk("post_rst_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1 chk("post_rst_empty1", 32'(out_valid), 32'h0);
      @(posedge clk); #1 chk("post_rst_empty2", 32'(out_valid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Decode/issue stage that feeds the RV32I ALU.
- Takes one fetched instruction per handshake, together with its PC and register-file operands.
- Decodes the instruction into the 5-bit ALU control code and orders the A/B operands the way the ALU consumes them.
- Registers the result toward the ALU with a valid/ready handshake. It is the producer end of the ALU's aluc/A/B interface.

Parameters:
- XLEN, 32, operand/PC width.
- ACW, 5, ALU control code width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  instruction valid
- in_ready_o  out  1  stage can accept
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction PC
- rs1_data_i  in  XLEN  rs1 value
- rs2_data_i  in  XLEN  rs2 value
- out_valid_o  out  1  issued op valid
- out_ready_i  in  1  ALU side accepts
- A_o  out  XLEN  ALU operand A
- B_o  out  XLEN  ALU operand B
- aluc_o  out  ACW  ALU control code
- rd_o  out  5  destination register
- we_o  out  1  register write enable
- illegal_o  out  1  undecodable instruction flag

Behaviour:
- Clock and reset are fixed: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: out_valid_o=0, illegal_o=0, we_o=0, A_o=B_o=0, aluc_o=0, rd_o=0. in_ready_o=1 once rst_ni is high.
- Reset asserted mid-operation discards all buffered entries immediately.
- Handshakes:
  - Input transfer occurs when in_valid_i & in_ready_o; output transfer occurs when out_valid_o & out_ready_i.
  - Output payload is held stable while out_valid_o=1 and out_ready_i=0.
- Latency: one cycle from input transfer to out_valid_o. Decode is combinational on the input side; the result is captured into the output register.
- aluc codes:
  - ADD 00000, SLL 00001, SLT 00010, SLTU 00011, XOR 00100, SRL 00101, OR 00110, AND 00111
  - SUB 01000, SRA 01101
  - BEQ 01110, BNE 01111, BLT 10100, BGE 10001, BLTU 10110, BGEU 10011
  - JAL/JALR 11111
- Operand order:
  - The ALU computes SLL as B<<A and SUB as B-A. For these two codes, A=rs2/shamt and B=rs1.
  - All other codes use A=rs1, B=rs2 or immediate.
- Decode by opcode:
  - OP 0110011: R-type, we=1. funct7 must be 0000000, or 0100000 only with funct3 000 (SUB) or 101 (SRA); otherwise illegal.
  - OP-IMM 0010011: B=sign-extended I-immediate, we=1.
    - Shifts use B={27'b0, instr[24:20]}; SLLI becomes A=shamt, B=rs1.
    - instr[30]=1 with funct3 101 selects SRAI. instr[31:25] other than 0000000/0100000 on a shift is illegal.
  - BRANCH 1100011: A=rs1, B=rs2, we=0, funct3 selects the branch code. funct3 010/011 is illegal.
  - JAL 1101111 / JALR 1100111: aluc=11111, A=pc_i+4, B=0, we=1.
  - LUI 0110111: ADD with A=0, B={instr[31:12],12'b0}.
  - AUIPC 0010111: ADD with A=pc_i, B={instr[31:12],12'b0}.
  - Any other opcode: illegal_o=1, we=0, aluc=0, A=B=0. The entry still issues and handshakes normally.
- rd_o=instr[11:7] for writing instructions and 0 for branches and illegal instructions. If rd=0, we_o is forced to 0.
- PC arithmetic wraps modulo 2^XLEN; pc_i=FFFFFFFC gives A=00000000 for JAL.
- Simultaneous input and output transfer in the same cycle is always allowed: pass-through with no bubble.

Optional Feature:
- Macro ALU_ISSUE_SKID_EN.
- Defined:
  - Two-entry skid buffer. in_ready_o is registered and equals "skid entry empty".
  - A stall captures the in-flight input into the skid entry. The skid entry drains before new input.
  - Full throughput; no combinational path from out_ready_i to in_ready_o.
- Undefined:
  - Single output register with in_ready_o = !out_valid_o | out_ready_i, which is a combinational path.

Test Plan:
- Reset: drive rst_ni=0 mid-stream with out_valid_o=1 -> out_valid_o=0 and all outputs 0 asynchronously; in_ready_o=1 after release.
- SUB x3,x1,x2, rs1=0x10, rs2=0x3 -> aluc=01000, A=0x3, B=0x10, rd=3, we=1, out_valid_o one cycle after transfer.
- SRAI x5,x6,4 (instr 0x40435293), rs1=0x80000000 -> aluc=01101, A=0x80000000, B=0x4. SLLI x5,x6,4 -> aluc=00001, A=0x4, B=rs1.
- BGEU funct3=111, rs1=5, rs2=7 -> aluc=10011, we=0, rd=0. JAL x1 at pc=0xFFFFFFFC -> aluc=11111, A=0x00000000, we=1.
- Back-pressure: stream 4 ADDIs with out_ready_i low for 3 cycles -> no entry lost or duplicated, payload stable. With ALU_ISSUE_SKID_EN, one handshake per cycle after release.
- Opcode 0x7F, and OP with funct7 0x01 -> illegal_o=1, we=0, aluc=0, A=B=0, issued in order with neighbours.
